arbitrated_main_memory_control: RTL and testbench
=================================================

# arbitrated_main_memory_control

Parametrised main-memory front end that multiplexes the instruction-fetch port and the data load/store port onto one single-ported synchronous memory. It replaces the fixed two-read-address wiring with valid/ready request handshakes, a registered memory command stage, and read-latency tracking. It sits between the pipeline's fetch/memory stages and main memory. Arbitration is data-first with an optional fetch starvation guard.

## Interface
- ADDR_WIDTH, 32, address width, both ports and memory
- DATA_WIDTH, 32, data word width
- READ_LATENCY, 1, memory read latency in cycles; legal range 1..4
- STARVE_LIMIT, 3, consecutive fetch denials before fetch is forced to win; legal range 1..15
- clk  input  1  clock; one clock domain
- rst  input  1  reset, asynchronous, active-high
- fetch_req_valid  input  1  fetch read request
- fetch_req_ready  output  1  fetch request accepted this cycle
- fetch_addr  input  ADDR_WIDTH  fetch address
- fetch_rsp_valid  output  1  fetch read data valid, single-cycle pulse
- fetch_rsp_data  output  DATA_WIDTH  fetch read data
- data_req_valid  input  1  data request
- data_req_ready  output  1  data request accepted this cycle
- data_req_write  input  1  1 = store, 0 = load
- data_addr  input  ADDR_WIDTH  load/store address
- data_wdata  input  DATA_WIDTH  store data
- data_rsp_valid  output  1  load data valid, single-cycle pulse; stores get no response
- data_rsp_data  output  DATA_WIDTH  load data
- mem_addr  output  ADDR_WIDTH  registered memory address
- mem_wdata  output  DATA_WIDTH  registered write data
- mem_re  output  1  registered read strobe
- mem_we  output  1  registered write strobe
- mem_rdata  input  DATA_WIDTH  memory read data

## Operation
- One memory operation per cycle. A request is accepted on the rising edge where valid and ready are both 1.
- Grant, evaluated combinationally each cycle:
  - data wins if data_req_valid, unless the guard forces fetch;
  - otherwise fetch wins if fetch_req_valid.
- ready = valid and grant, per port. Ready never asserts without valid, and at most one ready is high per cycle.
- Accepted request registers mem_addr, mem_wdata and mem_re/mem_we (mem_we = data_req_write on a data grant). With no grant, mem_re = mem_we = 0; mem_addr/mem_wdata hold.
- Tag pipeline: READ_LATENCY+1 stages of {valid, port}. Entry is pushed on every accepted read and shifts every cycle.
- When the tag reaches the last stage, rsp_valid of the tagged port is high and rsp_data = mem_rdata. The other port's rsp_data is don't-care; drive it with mem_rdata.
- Responses have no backpressure and return in issue order. Unlimited reads may be in flight.
- Reset, including mid-operation: all outputs low, tag pipeline cleared (in-flight reads are dropped, no response), starvation counter 0. mem_addr/mem_wdata reset to 0.

## Timing
- Request accepted at edge E. mem_* is valid in cycle E..E+1.
- mem_rdata is sampled in the cycle following edge E+READ_LATENCY; rsp_valid pulses in that same cycle. Load-to-use latency is READ_LATENCY+1 cycles.
- Back-to-back accepts on consecutive edges produce responses on consecutive cycles.
- Store followed by load to the same address on the next edge returns the new data, because the memory is in-order.
- ready is combinational from valid and the counter state. There is no combinational path from mem_rdata to ready.

## Configuration
- MEM_STARVE_GUARD_EN defined:
  - 4-bit counter increments on each cycle where fetch_req_valid=1 and fetch is not granted, saturating at 15;
  - it clears on a fetch grant or when fetch_req_valid=0;
  - when counter ≥ STARVE_LIMIT, fetch wins over data for that cycle, then the counter clears.
- MEM_STARVE_GUARD_EN undefined: strict data priority; the counter and STARVE_LIMIT are unused.

## Structure
- Shared defines file holds MEM_PORT_FETCH=0 / MEM_PORT_DATA=1 tag encodings, the READ_LATENCY bounds, and the tag-entry width.
- Sub-module mem_read_tag_pipe holds the parametrised {valid, port} shift register (depth READ_LATENCY+1) with asynchronous clear.
- The top module holds the arbiter, starvation counter and memory command registers.

## Test plan
- READ_LATENCY=1, fetch only, addrs 0x0,0x4,0x8 back-to-back, memory returns addr+0x100 → fetch_rsp_valid on 3 consecutive cycles, 2 cycles after each accept, data 0x100,0x104,0x108.
- Fetch and data load both valid, data 0x40 → data_req_ready=1, fetch_req_ready=0. Load response 0x140 appears on data port only; fetch is granted next cycle.
- Store 0xDEADBEEF to 0x20 then load 0x20 on the next edge → mem_we then mem_re, with no response for the store. data_rsp_data=0xDEADBEEF.
- Guard enabled, STARVE_LIMIT=3, data_req_valid held high with fetch valid → fetch granted on the 4th cycle, counter cleared, then data resumes. Guard disabled → fetch never granted.
- READ_LATENCY=3, issue 2 loads then assert rst for one cycle before data returns → no rsp_valid after reset, all outputs 0. The first post-reset load returns after 4 cycles.
- READ_LATENCY=4, alternating fetch/data accepts every cycle → responses strictly in order, each tagged to the correct port.

Source files
------------

// File: rtl/arbitrated_main_memory_control_pkg.sv
// Shared definitions for the arbitrated main-memory front end: port tag encodings,
// read-latency bounds and the in-flight read tag entry.
package arbitrated_main_memory_control_pkg;

  typedef enum logic {
    MEM_PORT_FETCH = 1'b0,
    MEM_PORT_DATA  = 1'b1
  } mem_port_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;

  typedef struct packed {
    logic      valid;
    mem_port_e port;
  } mem_tag_t;

  localparam int unsigned TAG_W = $bits(mem_tag_t);

endpackage

// File: rtl/arbitrated_main_memory_control_tag_pipe.sv
// Fixed-depth shift register of {valid, port} tags tracking reads in flight to memory;
// asynchronous clear drops every outstanding read.
module mem_read_tag_pipe
  import arbitrated_main_memory_control_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag
);

  logic [TAG_W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/arbitrated_main_memory_control.sv
// Single-port main-memory front end: data-first arbitration of fetch vs load/store,
// registered memory command, in-order read tagging. Optional: MEM_STARVE_GUARD_EN.
module arbitrated_main_memory_control
  import arbitrated_main_memory_control_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_valid,
  output logic                  fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_rsp_valid,
  output logic [DATA_WIDTH-1:0] fetch_rsp_data,
  input  logic                  data_req_valid,
  output logic                  data_req_ready,
  input  logic                  data_req_write,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_rsp_valid,
  output logic [DATA_WIDTH-1:0] data_rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned LP_LATENCY =
    (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
    (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;

  logic                  w_force_fetch;
  logic                  w_grant_fetch;
  logic                  w_grant_data;
  logic                  w_issue_read;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_re;
  logic                  r_mem_we;
  mem_tag_t              w_tag_in;
  mem_tag_t              w_tag_out;

`ifdef MEM_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  assign w_force_fetch = fetch_req_valid && (r_starve_cnt >= 4'(STARVE_LIMIT));

  // Clears on any fetch grant, which includes the forced one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!fetch_req_valid || w_grant_fetch) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != 4'hF) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  logic w_unused_starve_limit;

  assign w_force_fetch         = 1'b0;
  assign w_unused_starve_limit = ^4'(STARVE_LIMIT);
`endif

  always_comb begin
    w_grant_data  = data_req_valid && !w_force_fetch;
    w_grant_fetch = fetch_req_valid && !w_grant_data;
    w_issue_read  = w_grant_fetch || (w_grant_data && !data_req_write);
  end

  assign fetch_req_ready = w_grant_fetch;
  assign data_req_ready  = w_grant_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_mem_re <= w_issue_read;
      r_mem_we <= w_grant_data && data_req_write;
      if (w_grant_data) begin
        r_mem_addr  <= data_addr;
        r_mem_wdata <= data_wdata;
      end else if (w_grant_fetch) begin
        r_mem_addr  <= fetch_addr;
        r_mem_wdata <= data_wdata;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue_read;
    w_tag_in.port  = w_grant_data ? MEM_PORT_DATA : MEM_PORT_FETCH;
  end

  // Depth LATENCY+1: one stage for the command register, LATENCY for the memory.
  mem_read_tag_pipe #(
    .DEPTH(LP_LATENCY + 1)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign fetch_rsp_valid = w_tag_out.valid && (w_tag_out.port == MEM_PORT_FETCH);
  assign data_rsp_valid  = w_tag_out.valid && (w_tag_out.port == MEM_PORT_DATA);
  assign fetch_rsp_data  = mem_rdata;
  assign data_rsp_data   = mem_rdata;

endmodule

// File: tb/tb_arbitrated_main_memory_control.sv
// Directed bench for arbitrated_main_memory_control at READ_LATENCY 1, 3 and 4,
// each instance paired with a small in-order memory model.
module tb_arbitrated_main_memory_control;

  logic        clk;
  logic        rst;
  logic        fv   [3];
  logic        dv   [3];
  logic        dw   [3];
  logic [31:0] fa   [3];
  logic [31:0] da   [3];
  logic [31:0] dwd  [3];
  logic        frdy [3];
  logic        drdy [3];
  logic        frv  [3];
  logic        drv  [3];
  logic [31:0] frd  [3];
  logic [31:0] drd  [3];
  logic [31:0] maddr[3];
  logic [31:0] mwd  [3];
  logic        mre  [3];
  logic        mwe  [3];
  logic [31:0] mrd  [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned RL = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [31:0] mem  [64];
    logic [31:0] pipe [RL];

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i * 4);
    end

    always @(posedge clk) begin
      if (mwe[g]) mem[maddr[g][7:2]] <= mwd[g];
      pipe[0] <= mre[g] ? mem[maddr[g][7:2]] : 32'h0;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    assign mrd[g] = pipe[RL-1];

    arbitrated_main_memory_control #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .READ_LATENCY (RL),
      .STARVE_LIMIT (3)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_req_valid (fv[g]),
      .fetch_req_ready (frdy[g]),
      .fetch_addr      (fa[g]),
      .fetch_rsp_valid (frv[g]),
      .fetch_rsp_data  (frd[g]),
      .data_req_valid  (dv[g]),
      .data_req_ready  (drdy[g]),
      .data_req_write  (dw[g]),
      .data_addr       (da[g]),
      .data_wdata      (dwd[g]),
      .data_rsp_valid  (drv[g]),
      .data_rsp_data   (drd[g]),
      .mem_addr        (maddr[g]),
      .mem_wdata       (mwd[g]),
      .mem_re          (mre[g]),
      .mem_we          (mwe[g]),
      .mem_rdata       (mrd[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, " fetch_rsp_valid"}, 32'(frv[k]), 32'd0);
    check({tag, " data_rsp_valid"},  32'(drv[k]), 32'd0);
    check({tag, " mem_re"},          32'(mre[k]), 32'd0);
    check({tag, " mem_we"},          32'(mwe[k]), 32'd0);
    check({tag, " mem_addr"},        maddr[k],    32'd0);
    check({tag, " mem_wdata"},       mwd[k],      32'd0);
  endtask

  initial begin
    bit guard;
    int j;
    checks = 0;
    errors = 0;
`ifdef MEM_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      fv[k] = 0; dv[k] = 0; dw[k] = 0;
      fa[k] = '0; da[k] = '0; dwd[k] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check_idle(k, "reset");
      check("reset fetch_ready", 32'(frdy[k]), 32'd0);
      check("reset data_ready",  32'(drdy[k]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Fetch-only stream, latency 1
    fv[0] = 1; fa[0] = 32'h0; #1;
    check("t1 fready0", 32'(frdy[0]), 32'd1);
    check("t1 dready0", 32'(drdy[0]), 32'd0);
    tick();
    fa[0] = 32'h4; #1;
    check("t1 mem_re", 32'(mre[0]), 32'd1);
    check("t1 rsp early", 32'(frv[0]), 32'd0);
    tick();
    fa[0] = 32'h8; #1;
    check("t1 mem_addr", maddr[0], 32'h4);
    check("t1 rsp0 v", 32'(frv[0]), 32'd1);
    check("t1 rsp0 d", frd[0], 32'h100);
    tick();
    fv[0] = 0; #1;
    check("t1 rsp1 v", 32'(frv[0]), 32'd1);
    check("t1 rsp1 d", frd[0], 32'h104);
    tick();
    check("t1 rsp2 v", 32'(frv[0]), 32'd1);
    check("t1 rsp2 d", frd[0], 32'h108);
    check("t1 rsp2 no data", 32'(drv[0]), 32'd0);
    tick();
    check("t1 rsp end", 32'(frv[0]), 32'd0);

    // Data beats fetch; fetch follows
    fv[0] = 1; fa[0] = 32'h10; dv[0] = 1; dw[0] = 0; da[0] = 32'h40; #1;
    check("t2 dready", 32'(drdy[0]), 32'd1);
    check("t2 fready", 32'(frdy[0]), 32'd0);
    tick();
    dv[0] = 0; #1;
    check("t2 fready next", 32'(frdy[0]), 32'd1);
    tick();
    fv[0] = 0; #1;
    check("t2 load v", 32'(drv[0]), 32'd1);
    check("t2 load d", drd[0], 32'h140);
    check("t2 load not fetch", 32'(frv[0]), 32'd0);
    tick();
    check("t2 fetch v", 32'(frv[0]), 32'd1);
    check("t2 fetch d", frd[0], 32'h110);
    check("t2 fetch not data", 32'(drv[0]), 32'd0);
    tick();

    // Store then load same address
    dv[0] = 1; dw[0] = 1; da[0] = 32'h20; dwd[0] = 32'hDEADBEEF; #1;
    check("t3 st ready", 32'(drdy[0]), 32'd1);
    tick();
    dw[0] = 0; #1;
    check("t3 mem_we", 32'(mwe[0]), 32'd1);
    check("t3 st no re", 32'(mre[0]), 32'd0);
    check("t3 st addr", maddr[0], 32'h20);
    check("t3 st wdata", mwd[0], 32'hDEADBEEF);
    tick();
    dv[0] = 0; #1;
    check("t3 ld re", 32'(mre[0]), 32'd1);
    check("t3 ld no we", 32'(mwe[0]), 32'd0);
    check("t3 st no rsp", 32'(drv[0]), 32'd0);
    tick();
    check("t3 ld v", 32'(drv[0]), 32'd1);
    check("t3 ld d", drd[0], 32'hDEADBEEF);
    tick();
    check("t3 single rsp", 32'(drv[0]), 32'd0);

    // Starvation guard vs strict priority
    dv[0] = 1; dw[0] = 0; da[0] = 32'h0; fv[0] = 1; fa[0] = 32'h30;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("t4 fready", 32'(frdy[0]), 32'(guard && (i == 3)));
      check("t4 dready", 32'(drdy[0]), 32'(!(guard && (i == 3))));
      tick();
    end
    dv[0] = 0; fv[0] = 0;
    for (int i = 0; i < 4; i++) tick();

    // Reset with reads in flight, latency 3
    dv[1] = 1; dw[1] = 0; da[1] = 32'h4;
    tick();
    da[1] = 32'h8;
    tick();
    dv[1] = 0;
    tick();
    rst = 1'b1; #1;
    check_idle(1, "t5 rst");
    tick();
    check("t5 rst hold", 32'(drv[1]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t5 dropped", 32'(drv[1] | frv[1]), 32'd0);
      tick();
    end
    dv[1] = 1; da[1] = 32'hC; #1;
    check("t5 post ready", 32'(drdy[1]), 32'd1);
    tick();
    dv[1] = 0;
    tick();
    tick();
    check("t5 post early", 32'(drv[1]), 32'd0);
    tick();
    check("t5 post v", 32'(drv[1]), 32'd1);
    check("t5 post d", drd[1], 32'h10C);

    // Alternating ports, latency 4
    for (int k = 0; k < 12; k++) begin
      fv[2] = 0; dv[2] = 0; dw[2] = 0;
      if (k < 6) begin
        if (k % 2 == 0) begin
          fv[2] = 1; fa[2] = 32'h40 + 32'(4 * k);
        end else begin
          dv[2] = 1; da[2] = 32'h80 + 32'(4 * k);
        end
      end
      #1;
      if (k < 6) begin
        check("t6 fready", 32'(frdy[2]), 32'(k % 2 == 0));
        check("t6 dready", 32'(drdy[2]), 32'(k % 2 == 1));
      end
      j = k - 5;
      if (j >= 0 && j < 6) begin
        check("t6 fetch v", 32'(frv[2]), 32'(j % 2 == 0));
        check("t6 data v",  32'(drv[2]), 32'(j % 2 == 1));
        if (j % 2 == 0) check("t6 fetch d", frd[2], 32'h140 + 32'(4 * j));
        else            check("t6 data d",  drd[2], 32'h180 + 32'(4 * j));
      end else begin
        check("t6 quiet", 32'(frv[2] | drv[2]), 32'd0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
